// File: rtl/morse_lcd_scheduler_if.sv
// morse_lcd_scheduler_if
//   Groups the two requester handshakes (decoded characters, raw LCD commands)
//   and the lcd2 driver strobe/data/done signals shared by the scheduler.
//   master : the environment side (Morse decoder, command source, lcd2 driver)
//   slave  : the scheduler side
//   Signals:
//     char_valid/char_data/char_ready  character offer and FIFO acceptance
//     cmd_valid/cmd_data/cmd_ready     command offer and acceptance (IDLE only)
//     lcd_data/lcd_oper/lcd_enb        byte, write type and strobe to lcd2
//     lcd_done                         lcd2 completion pulse
interface morse_lcd_scheduler_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] lcd_data;
  logic       lcd_oper;
  logic       lcd_enb;
  logic       lcd_done;

  modport master (
    output char_valid, char_data, cmd_valid, cmd_data, lcd_done,
    input  char_ready, cmd_ready, lcd_data, lcd_oper, lcd_enb
  );

  modport slave (
    input  char_valid, char_data, cmd_valid, cmd_data, lcd_done,
    output char_ready, cmd_ready, lcd_data, lcd_oper, lcd_enb
  );
endinterface

// File: rtl/morse_lcd_scheduler.sv
// morse_lcd_scheduler
//   Arbitrates all writes to the lcd2 character driver. Raw commands take
//   priority over buffered Morse characters. The cursor of a 2 x LINE_LEN
//   display is tracked here; when a row fills, the scheduler itself issues
//   0xC0 (go to row 1) or 0x01 (clear, back to row 0).
//   Ports:
//     clock_debouced  in   block clock, rising edge
//     reset           in   synchronous, active-low
//     bus             slave side of morse_lcd_scheduler_if (handshakes, lcd2)
//     fifo_count      out  character FIFO occupancy (0..FIFO_DEPTH)
//     cursor_col      out  next write column
//     cursor_row      out  next write row
//     overflow        out  sticky: character offered while FIFO full
//     timeout         out  sticky: a write completed because lcd_done never came
module morse_lcd_scheduler #(
  parameter int FIFO_DEPTH  = 8,
  parameter int LINE_LEN    = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                 clock_debouced,
  input  logic                 reset,
  morse_lcd_scheduler_if.slave bus,
  output logic [4:0]           fifo_count,
  output logic [4:0]           cursor_col,
  output logic                 cursor_row,
  output logic                 overflow,
  output logic                 timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ROW1  = 8'hC0;
  localparam logic [7:0] CHAR_UNK  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    MOVE_ISSUE,
    MOVE_WAIT
  } state_t;

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [9:0]    wait_cnt, wait_next;
  logic [7:0]    data_q, data_next;
  logic          oper_q, oper_next;
  logic [4:0]    col_next;
  logic          row_next;
  logic          pop;
  logic          timeout_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, cmd_take, wait_over;

  assign full      = (fifo_count == 5'(FIFO_DEPTH));
  assign empty     = (fifo_count == 5'd0);
  assign push      = bus.char_valid && bus.char_ready;
  assign cmd_take  = bus.cmd_valid && bus.cmd_ready;
  // A wait ends on the done pulse, or is forced once the counter reaches TIMEOUT.
  assign wait_over = bus.lcd_done || (wait_cnt == 10'(TIMEOUT));

  // Ready signals are gated by reset so nothing is accepted while reset is low.
  assign bus.char_ready = reset && !full;
  assign bus.cmd_ready  = reset && (state == IDLE);
  assign bus.lcd_enb    = (state == ISSUE) || (state == MOVE_ISSUE);
  assign bus.lcd_data   = data_q;
  assign bus.lcd_oper   = oper_q;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    wait_next   = wait_cnt;
    data_next   = data_q;
    oper_next   = oper_q;
    col_next    = cursor_col;
    row_next    = cursor_row;
    pop         = 1'b0;
    timeout_set = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_take) begin
          data_next  = bus.cmd_data;
          oper_next  = 1'b0;
          hold_next  = '0;
          state_next = ISSUE;
        end else if (!empty) begin
          pop        = 1'b1;
          data_next  = mem[rd_ptr];
          oper_next  = 1'b1;
          hold_next  = '0;
          state_next = ISSUE;
        end
      end

      ISSUE, MOVE_ISSUE: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          wait_next  = '0;
          state_next = (state == ISSUE) ? WAIT_DONE : MOVE_WAIT;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (wait_over) begin
          timeout_set = !bus.lcd_done;
          state_next  = IDLE;
          if (oper_q) begin
            if (cursor_col == 5'(LINE_LEN - 1)) begin
              // Row is full: the column holds at the last position until the
              // automatic move command lands.
              data_next  = cursor_row ? CMD_CLEAR : CMD_ROW1;
              oper_next  = 1'b0;
              hold_next  = '0;
              state_next = MOVE_ISSUE;
            end else begin
              col_next = cursor_col + 5'd1;
            end
          end else if (data_q == CMD_CLEAR || data_q == CMD_HOME) begin
            col_next = 5'd0;
            row_next = 1'b0;
          end
        end else begin
          wait_next = wait_cnt + 10'd1;
        end
      end

      MOVE_WAIT: begin
        if (wait_over) begin
          timeout_set = !bus.lcd_done;
          col_next    = 5'd0;
          row_next    = !cursor_row;
          state_next  = IDLE;
        end else begin
          wait_next = wait_cnt + 10'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_debouced) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      wait_cnt   <= '0;
      data_q     <= '0;
      oper_q     <= 1'b0;
      cursor_col <= '0;
      cursor_row <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      wait_cnt   <= wait_next;
      data_q     <= data_next;
      oper_q     <= oper_next;
      cursor_col <= col_next;
      cursor_row <= row_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (bus.char_valid && full) overflow <= 1'b1;
      if (timeout_set)            timeout  <= 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clock_debouced) begin
    if (push) mem[wr_ptr] <= (bus.char_data == 8'd0) ? CHAR_UNK : bus.char_data;
  end

endmodule

// File: tb/tb_morse_lcd_scheduler.sv
// tb_morse_lcd_scheduler
//   Directed stimulus for morse_lcd_scheduler. Every expected lcd2 write is
//   pushed into a queue when the stimulus is issued; a monitor pops and
//   compares on each rising lcd_enb and answers with lcd_done when enabled.
module tb_morse_lcd_scheduler;
  localparam int DEPTH = 8;
  localparam int LINE  = 16;
  localparam int HOLD  = 4;
  localparam int TOUT  = 1023;

  logic       clock_debouced = 1'b0;
  logic       reset          = 1'b0;
  logic [4:0] fifo_count, cursor_col;
  logic       cursor_row, overflow, timeout;

  always #5 clock_debouced = ~clock_debouced;

  morse_lcd_scheduler_if bus ();

  morse_lcd_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .LINE_LEN   (LINE),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT    (TOUT)
  ) dut (
    .clock_debouced(clock_debouced),
    .reset         (reset),
    .bus           (bus),
    .fifo_count    (fifo_count),
    .cursor_col    (cursor_col),
    .cursor_row    (cursor_row),
    .overflow      (overflow),
    .timeout       (timeout)
  );

  typedef struct packed {
    logic       oper;
    logic [7:0] data;
    logic       chk_cur;
    logic       row;
    logic [4:0] col;
  } wr_t;

  wr_t  exp_q[$];
  int   errors    = 0;
  int   checks    = 0;
  logic auto_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void expect_wr(input logic oper, input logic [7:0] d,
                                    input logic chk, input logic r, input logic [4:0] c);
    exp_q.push_back(wr_t'{oper, d, chk, r, c});
  endfunction

  // Monitor and lcd2 responder: compares each write at strobe start, checks
  // the strobe width, and pulses lcd_done two cycles after the strobe ends.
  initial begin
    int   width = 0;
    int   done_timer = 0;
    logic prev = 1'b0;
    wr_t  e;
    bus.lcd_done = 1'b0;
    forever begin
      @(negedge clock_debouced);
      bus.lcd_done = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) bus.lcd_done = 1'b1;
      end
      if (bus.lcd_enb && !prev) begin
        width = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: data 0x%0h oper %0b with empty queue (t=%0t)",
                   bus.lcd_data, bus.lcd_oper, $time);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(bus.lcd_data), 32'(e.data));
          check("wr_oper", 32'(bus.lcd_oper), 32'(e.oper));
          if (e.chk_cur) begin
            check("wr_row", 32'(cursor_row), 32'(e.row));
            check("wr_col", 32'(cursor_col), 32'(e.col));
          end
        end
      end else if (bus.lcd_enb) begin
        width++;
      end else if (prev) begin
        check("enb_width", 32'(width), 32'(HOLD));
        if (auto_done) done_timer = 2;
      end
      prev = bus.lcd_enb;
    end
  end

  task automatic send_char(input logic [7:0] d);
    logic acc = 1'b0;
    @(negedge clock_debouced);
    bus.char_valid = 1'b1;
    bus.char_data  = d;
    for (int i = 0; i < 3000; i++) begin
      #4 acc = bus.char_ready;
      @(negedge clock_debouced);
      if (acc) break;
    end
    bus.char_valid = 1'b0;
    check("char_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] d);
    logic acc = 1'b0;
    @(negedge clock_debouced);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    for (int i = 0; i < 3000; i++) begin
      #4 acc = bus.cmd_ready;
      @(negedge clock_debouced);
      if (acc) break;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  // Waits until every expected write has started and the block is back in
  // IDLE with an empty FIFO.
  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock_debouced);
      #1;
      if (exp_q.size() == 0 && fifo_count == 5'd0 && bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    logic seen;
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h41;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = 8'h00;

    // T1: reset held low for three edges with a character offered.
    repeat (3) @(negedge clock_debouced);
    #1;
    check("rst_char_ready", 32'(bus.char_ready), 32'd0);
    check("rst_cmd_ready",  32'(bus.cmd_ready),  32'd0);
    check("rst_lcd_enb",    32'(bus.lcd_enb),    32'd0);
    check("rst_lcd_data",   32'(bus.lcd_data),   32'd0);
    check("rst_lcd_oper",   32'(bus.lcd_oper),   32'd0);
    check("rst_fifo_count", 32'(fifo_count),     32'd0);
    check("rst_cursor",     32'({cursor_row, cursor_col}), 32'd0);
    check("rst_flags",      32'({overflow, timeout}),      32'd0);
    bus.char_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock_debouced);
    #1;
    check("post_rst_ready", 32'({bus.cmd_ready, bus.char_ready}), 32'b11);

    // T2: two characters, lcd_done two cycles after each strobe.
    auto_done = 1'b1;
    expect_wr(1'b1, 8'd97, 1'b1, 1'b0, 5'd0);
    expect_wr(1'b1, 8'd98, 1'b1, 1'b0, 5'd1);
    send_char(8'd97);
    send_char(8'd98);
    wait_idle("t2_idle");
    check("t2_col", 32'(cursor_col), 32'd2);
    check("t2_row", 32'(cursor_row), 32'd0);

    // T3: clear command and 'e' offered together; the command goes first.
    expect_wr(1'b0, 8'h01, 1'b1, 1'b0, 5'd2);
    expect_wr(1'b1, 8'd101, 1'b1, 1'b0, 5'd0);
    fork
      send_cmd(8'h01);
      send_char(8'd101);
    join
    wait_idle("t3_idle");
    check("t3_col", 32'(cursor_col), 32'd1);
    check("t3_row", 32'(cursor_row), 32'd0);

    // T4: fill both rows; 0xC0 after the 16th char, 0x01 after the 32nd.
    expect_wr(1'b0, 8'h02, 1'b1, 1'b0, 5'd1);
    send_cmd(8'h02);
    for (int i = 0; i < 2 * LINE; i++) begin
      expect_wr(1'b1, 8'(8'h41 + (i % 26)), 1'b1, 1'(i / LINE), 5'(i % LINE));
      if (i == LINE - 1)     expect_wr(1'b0, 8'hC0, 1'b0, 1'b0, 5'd0);
      if (i == 2 * LINE - 1) expect_wr(1'b0, 8'h01, 1'b0, 1'b0, 5'd0);
      send_char(8'(8'h41 + (i % 26)));
    end
    wait_idle("t4_idle");
    check("t4_cursor", 32'({cursor_row, cursor_col}), 32'd0);

    // T5: lcd_done held low. 'A' is taken at once, 'B'..'I' fill the FIFO,
    // 'J'..'L' are dropped and raise overflow.
    auto_done = 1'b0;
    for (int k = 0; k < 9; k++) expect_wr(1'b1, 8'(8'h41 + k), 1'b1, 1'b0, 5'(k));
    for (int k = 0; k < 12; k++) begin
      @(negedge clock_debouced);
      bus.char_valid = 1'b1;
      bus.char_data  = 8'(8'h41 + k);
    end
    @(negedge clock_debouced);
    bus.char_valid = 1'b0;
    #1;
    check("t5_fifo_count", 32'(fifo_count),     32'(DEPTH));
    check("t5_overflow",   32'(overflow),       32'd1);
    check("t5_char_ready", 32'(bus.char_ready), 32'd0);
    repeat (1000) @(negedge clock_debouced);
    check("t5_no_early_timeout", 32'(timeout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_debouced);
      if (timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_timeout", 32'(seen), 32'd1);
    auto_done = 1'b1;
    wait_idle("t5_idle");
    check("t5_col", 32'(cursor_col), 32'd9);
    check("t5_overflow_sticky", 32'(overflow), 32'd1);

    // T6: unrecognised pattern shows as '?', then reset during WAIT_DONE.
    auto_done = 1'b0;
    expect_wr(1'b1, 8'h3F, 1'b1, 1'b0, 5'd9);
    send_char(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock_debouced);
      if (bus.lcd_enb) seen = 1'b1;
      else if (seen) break;
    end
    check("t6_strobe_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clock_debouced);
    reset = 1'b0;
    @(negedge clock_debouced);
    #1;
    check("t6_rst_enb",    32'(bus.lcd_enb),   32'd0);
    check("t6_rst_ready",  32'({bus.cmd_ready, bus.char_ready}), 32'd0);
    check("t6_rst_data",   32'(bus.lcd_data),  32'd0);
    check("t6_rst_flags",  32'({overflow, timeout}), 32'd0);
    check("t6_rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    reset = 1'b1;
    @(negedge clock_debouced);
    #1;
    check("t6_idle_after_rst", 32'(bus.cmd_ready), 32'd1);
    repeat (10) @(negedge clock_debouced);
    check("t6_no_restrobe", 32'(bus.lcd_enb), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
